// File: rtl/uart_pkg.sv
// Shared types and widths for the UART RX byte-sequence checker.
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int ERR_W  = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;
endpackage

// File: rtl/uart_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module uart_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                     cnt_d = '0;
    else if (inc && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/uart_rx_checker.sv
// Reads bytes from an RX FIFO and checks them against an incrementing
// sequence starting at START_VAL; reports counts and the first mismatch.
module uart_rx_checker
  import uart_pkg::*;
#(
  parameter int                NUM_BYTES = 16,
  parameter logic [DATA_W-1:0] START_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  input  logic              rx_fifo_empty,
  input  logic [DATA_W-1:0] rx_fifo_data_out,
  output logic              rx_rd_en,
  output logic              byte_valid,
  output logic [DATA_W-1:0] byte_data,
  output logic              mismatch,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [ERR_W-1:0]  first_err,
  output logic              done
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic [DATA_W-1:0] byte_data_q, byte_data_d;
  logic              mismatch_q, mismatch_d;
  logic [ERR_W-1:0]  first_err_q, first_err_d;
  logic              rx_rd_en_q, rx_rd_en_d;
  logic              byte_valid_q, byte_valid_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  rx_count_w, err_count_w;
  logic              can_read, last_byte, rx_inc, err_inc;

  assign can_read  = enable && !rx_fifo_empty && !clear;
  assign last_byte = (rx_count_w == LAST_CNT);
  assign rx_inc    = (state_q == S_CHECK);
  assign err_inc   = rx_inc && mismatch_q;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state. CHECK folds in the IDLE read decision so a steady
  // stream sustains one byte every three cycles.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (can_read) state_d = S_READ;
        S_READ:  state_d = S_WAIT;
        S_WAIT:  state_d = S_CHECK;
        S_CHECK: begin
          if (last_byte)     state_d = S_DONE;
          else if (can_read) state_d = S_READ;
          else               state_d = S_IDLE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs decoded from the next state so they can be registered
  always_comb begin
    rx_rd_en_d   = (state_d == S_READ);
    byte_valid_d = (state_d == S_CHECK);
    done_d       = (state_d == S_DONE);
  end

  always_comb begin
    byte_data_d = byte_data_q;
    mismatch_d  = 1'b0;
    expected_d  = expected_q;
    first_err_d = first_err_q;
    if (clear) begin
      expected_d  = START_VAL;
      first_err_d = '0;
    end else begin
      if (state_q == S_WAIT) begin
        byte_data_d = rx_fifo_data_out;
        mismatch_d  = (rx_fifo_data_out != expected_q);
      end
      if (state_q == S_CHECK) begin
        expected_d = expected_q + 1'b1;
        if (mismatch_q && err_count_w == '0)
          first_err_d = {expected_q, byte_data_q};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q   <= START_VAL;
      byte_data_q  <= '0;
      mismatch_q   <= 1'b0;
      first_err_q  <= '0;
      rx_rd_en_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      expected_q   <= expected_d;
      byte_data_q  <= byte_data_d;
      mismatch_q   <= mismatch_d;
      first_err_q  <= first_err_d;
      rx_rd_en_q   <= rx_rd_en_d;
      byte_valid_q <= byte_valid_d;
      done_q       <= done_d;
    end
  end

  uart_sat_cnt #(.W(CNT_W)) u_rx_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (rx_inc),
    .cnt_o (rx_count_w)
  );

  uart_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clear),
    .inc   (err_inc),
    .cnt_o (err_count_w)
  );

  assign rx_rd_en   = rx_rd_en_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign mismatch   = mismatch_q;
  assign rx_count   = rx_count_w;
  assign err_count  = err_count_w;
  assign first_err  = first_err_q;
  assign done       = done_q;
endmodule

// File: tb/tb_uart_rx_checker.sv
// Scoreboard bench for uart_rx_checker: a default instance plus a wrap instance.
module tb_uart_rx_checker;
  logic clk = 1'b0;
  logic rst, enable, clear, w_en;

  logic       rx_fifo_empty, rx_rd_en, byte_valid, mismatch, done;
  logic [7:0] rx_fifo_data_out = 8'h00;
  logic [7:0] byte_data;
  logic [15:0] rx_count, err_count, first_err;

  logic       w_empty, w_rd, w_bv, w_mm, w_done;
  logic [7:0] w_dout = 8'h00;
  logic [7:0] w_bd;
  logic [15:0] w_rc, w_ec, w_fe;

  logic [7:0] mem  [0:255];
  logic [7:0] mem2 [0:15];
  int wr_ptr = 0, rd_ptr = 0, wr2 = 0, rd2 = 0;

  logic [8:0] sb[$], sb2[$];
  logic [7:0] exp_v, exp2;
  int total = 0, passed = 0;
  int cyc = 0, rd_cnt = 0, last_rd = -1, gap_bad = 0;

  always #5 clk = ~clk;

  assign rx_fifo_empty = (wr_ptr == rd_ptr);
  assign w_empty       = (wr2 == rd2);

  always @(posedge clk) if (rx_rd_en) begin
    rx_fifo_data_out <= mem[rd_ptr[7:0]];
    rd_ptr <= rd_ptr + 1;
  end

  always @(posedge clk) if (w_rd) begin
    w_dout <= mem2[rd2[3:0]];
    rd2 <= rd2 + 1;
  end

  uart_rx_checker u_dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .rx_fifo_empty(rx_fifo_empty), .rx_fifo_data_out(rx_fifo_data_out),
    .rx_rd_en(rx_rd_en), .byte_valid(byte_valid), .byte_data(byte_data),
    .mismatch(mismatch), .rx_count(rx_count), .err_count(err_count),
    .first_err(first_err), .done(done)
  );

  uart_rx_checker #(.NUM_BYTES(3), .START_VAL(8'hFE)) u_wrap (
    .clk(clk), .rst(rst), .enable(w_en), .clear(1'b0),
    .rx_fifo_empty(w_empty), .rx_fifo_data_out(w_dout),
    .rx_rd_en(w_rd), .byte_valid(w_bv), .byte_data(w_bd),
    .mismatch(w_mm), .rx_count(w_rc), .err_count(w_ec),
    .first_err(w_fe), .done(w_done)
  );

  // Advance to the next falling edge; pop the scoreboards on each byte_valid.
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    cyc++;
    if (rx_rd_en) begin
      rd_cnt++;
      if (last_rd >= 0 && cyc - last_rd != 3) gap_bad++;
      last_rd = cyc;
    end
    if (byte_valid) begin
      total++;
      if (sb.size() == 0) $display("FAIL sb_main unexpected byte_valid got %h required none", byte_data);
      else begin
        e = sb.pop_front();
        if ({mismatch, byte_data} !== e) $display("FAIL sb_main {mismatch,data} got %h required %h", {mismatch, byte_data}, e);
        else passed++;
      end
    end
    if (w_bv) begin
      total++;
      if (sb2.size() == 0) $display("FAIL sb_wrap unexpected byte_valid got %h required none", w_bd);
      else begin
        e = sb2.pop_front();
        if ({w_mm, w_bd} !== e) $display("FAIL sb_wrap {mismatch,data} got %h required %h", {w_mm, w_bd}, e);
        else passed++;
      end
    end
  endtask

  task automatic push(input logic [7:0] b, input bit counted);
    mem[wr_ptr[7:0]] = b;
    wr_ptr++;
    if (counted) begin
      sb.push_back({b != exp_v, b});
      exp_v++;
    end
  endtask

  task automatic wait_rd();
    int n = 0;
    rd_cnt = 0;
    while (rd_cnt == 0 && n < 20) begin step(); n++; end
    total++;
    if (rd_cnt == 0) $display("FAIL wait_rd timeout got no rx_rd_en required one");
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clear = 1'b0; w_en = 1'b0;
    repeat (3) step();
    total++;
    if ({rx_rd_en, byte_valid, mismatch, done} !== 4'b0) $display("FAIL reset_flags got %b required 0000", {rx_rd_en, byte_valid, mismatch, done});
    else passed++;
    total++;
    if ({byte_data, rx_count, err_count, first_err} !== 56'h0) $display("FAIL reset_values got %h required 0", {byte_data, rx_count, err_count, first_err});
    else passed++;
    total++;
    if ({w_rd, w_bv, w_mm, w_done, w_bd, w_rc, w_ec, w_fe} !== 60'h0) $display("FAIL reset_wrap got %h required 0", {w_rd, w_bv, w_mm, w_done, w_bd, w_rc, w_ec, w_fe});
    else passed++;
    rst = 1'b0;
    exp_v = 8'h00;
    exp2 = 8'hFE;
  endtask

  task automatic test_stream();
    int n = 0;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    gap_bad = 0; last_rd = -1; rd_cnt = 0;
    enable = 1'b1;
    while (!done && n < 120) begin step(); n++; end
    total++;
    if (done !== 1'b1) $display("FAIL stream_done got %b required 1", done); else passed++;
    total++;
    if (rd_cnt != 16) $display("FAIL stream_reads got %0d required 16", rd_cnt); else passed++;
    total++;
    if (gap_bad != 0) $display("FAIL stream_rd_spacing got %0d bad gaps required 0", gap_bad); else passed++;
    total++;
    if (rx_count !== 16'd16 || err_count !== 16'd0) $display("FAIL stream_counts got rx=%0d err=%0d required rx=16 err=0", rx_count, err_count);
    else passed++;
    total++;
    if (sb.size() != 0) $display("FAIL stream_drain got %0d pending required 0", sb.size()); else passed++;
    push(8'h10, 1'b0);
    rd_cnt = 0;
    repeat (10) step();
    total++;
    if (rd_cnt != 0 || done !== 1'b1) $display("FAIL done_hold got reads=%0d done=%b required reads=0 done=1", rd_cnt, done);
    else passed++;
  endtask

  task automatic test_mismatch();
    int n = 0;
    enable = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    wr_ptr = rd_ptr;
    exp_v = 8'h00;
    step();
    total++;
    if ({rx_count, err_count, done} !== 33'h0) $display("FAIL clear_from_done got rx=%0d err=%0d done=%b required 0", rx_count, err_count, done);
    else passed++;
    push(8'h00, 1'b1); push(8'h01, 1'b1); push(8'h02, 1'b1); push(8'h07, 1'b1); push(8'h04, 1'b1);
    enable = 1'b1;
    while (rx_count != 16'd5 && n < 60) begin step(); n++; end
    total++;
    if (rx_count !== 16'd5 || err_count !== 16'd1) $display("FAIL mismatch_counts got rx=%0d err=%0d required rx=5 err=1", rx_count, err_count);
    else passed++;
    total++;
    if (first_err !== 16'h0307) $display("FAIL mismatch_first_err got %h required 0307", first_err); else passed++;
    total++;
    if (done !== 1'b0) $display("FAIL mismatch_not_done got %b required 0", done); else passed++;
  endtask

  task automatic test_enable_drop();
    push(8'h05, 1'b1);
    push(8'h06, 1'b0);
    enable = 1'b1;
    wait_rd();
    step();
    enable = 1'b0;
    rd_cnt = 0;
    repeat (15) step();
    total++;
    if (rd_cnt != 0) $display("FAIL enable_drop_reads got %0d required 0", rd_cnt); else passed++;
    total++;
    if (rx_count !== 16'd6 || wr_ptr - rd_ptr != 1) $display("FAIL enable_drop_state got rx=%0d fifo=%0d required rx=6 fifo=1", rx_count, wr_ptr - rd_ptr);
    else passed++;
  endtask

  task automatic test_clear();
    int n = 0;
    enable = 1'b1;
    wait_rd();
    step();
    clear = 1'b1; enable = 1'b0;
    step();
    clear = 1'b0;
    total++;
    if ({byte_valid, done, rx_count, err_count, first_err} !== 50'h0) $display("FAIL clear_in_wait got bv=%b done=%b rx=%0d err=%0d fe=%h required all 0", byte_valid, done, rx_count, err_count, first_err);
    else passed++;
    exp_v = 8'h00;
    push(8'h00, 1'b1);
    push(8'h05, 1'b1);
    rd_cnt = 0;
    enable = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    total++;
    if (rd_cnt != 0) $display("FAIL clear_beats_read got reads=%0d required 0", rd_cnt); else passed++;
    while (rx_count != 16'd2 && n < 30) begin step(); n++; end
    total++;
    if (rx_count !== 16'd2 || err_count !== 16'd1 || first_err !== 16'h0105) $display("FAIL clear_restart got rx=%0d err=%0d fe=%h required rx=2 err=1 fe=0105", rx_count, err_count, first_err);
    else passed++;
  endtask

  task automatic test_reset_in_check();
    push(8'h02, 1'b1);
    wait_rd();
    step();
    step();
    rst = 1'b1;
    step();
    total++;
    if ({rx_rd_en, byte_valid, mismatch, done} !== 4'b0 || {byte_data, rx_count, err_count, first_err} !== 56'h0) $display("FAIL reset_in_check got flags=%b data=%h rx=%0d err=%0d fe=%h required all 0", {rx_rd_en, byte_valid, mismatch, done}, byte_data, rx_count, err_count, first_err);
    else passed++;
    rst = 1'b0;
    exp_v = 8'h00;
    rd_cnt = 0;
    repeat (10) step();
    total++;
    if (rd_cnt != 0) $display("FAIL empty_no_read got reads=%0d required 0", rd_cnt); else passed++;
  endtask

  task automatic test_wrap();
    int n = 0;
    logic [7:0] vals [3];
    vals[0] = 8'hFE; vals[1] = 8'hFF; vals[2] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      mem2[wr2[3:0]] = vals[i];
      wr2++;
      sb2.push_back({vals[i] != exp2, vals[i]});
      exp2++;
    end
    w_en = 1'b1;
    while (!w_done && n < 40) begin step(); n++; end
    total++;
    if (w_done !== 1'b1 || w_rc !== 16'd3 || w_ec !== 16'd0) $display("FAIL wrap_result got done=%b rx=%0d err=%0d required done=1 rx=3 err=0", w_done, w_rc, w_ec);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_mismatch();
    test_enable_drop();
    test_clear();
    test_wrap();
    test_reset_in_check();
    total++;
    if (sb.size() != 0 || sb2.size() != 0) $display("FAIL sb_leftover got %0d/%0d pending required 0/0", sb.size(), sb2.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_checker.md
UART_RX_CHECKER -- requirements
Module: uart_rx_checker

Interface
REQ-001 Parameter NUM_BYTES, default 16: number of bytes checked before done.
REQ-002 Parameter START_VAL, default 8'h00: first expected byte value.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  level; high permits new reads from RX FIFO.
REQ-006 clear  input  1  one-cycle pulse; restarts the check sequence without reset.
REQ-007 rx_fifo_empty  input  1  RX FIFO empty flag; do not read when high.
REQ-008 rx_fifo_data_out  input  8  RX FIFO read data; valid the cycle after rx_rd_en.
REQ-009 rx_rd_en  output  1  one-cycle RX FIFO read strobe.
REQ-010 byte_valid  output  1  one-cycle pulse; byte_data holds the checked byte.
REQ-011 byte_data  output  8  last byte read.
REQ-012 mismatch  output  1  one-cycle pulse, coincident with byte_valid, when byte differs from expected.
REQ-013 rx_count  output  16  bytes checked, saturating.
REQ-014 err_count  output  16  mismatches, saturating.
REQ-015 first_err  output  16  {expected, received} of first mismatch; holds until reset/clear.
REQ-016 done  output  1  level; high once rx_count reaches NUM_BYTES.

Function
REQ-017 FSM states IDLE, READ, WAIT, CHECK, DONE; one-hot or binary encoding is free.
REQ-018 IDLE->READ when enable=1, rx_fifo_empty=0, clear=0; else stay in IDLE.
REQ-019 READ: rx_rd_en=1 for exactly this cycle; always proceeds to WAIT.
REQ-020 WAIT: rx_rd_en=0; register rx_fifo_data_out into byte_data; proceeds to CHECK.
REQ-021 CHECK: byte_valid=1; compare byte_data with expected; expected<=expected+1 (8-bit, 8'hFF wraps to 8'h00); rx_count+1.
REQ-022 CHECK with mismatch: mismatch=1, err_count+1; first_err captured only when err_count was 0.
REQ-023 Expected value advances on every checked byte, whether matched or not (no resync).
REQ-024 CHECK->DONE when incremented rx_count equals NUM_BYTES; else CHECK->IDLE.
REQ-025 Throughput: at most one byte per 3 clk cycles; latency rx_rd_en to byte_valid = 2 cycles.
REQ-026 DONE: done=1, no reads issued regardless of enable/empty; exit only via clear or rst.
REQ-027 enable falling during READ/WAIT/CHECK: in-flight byte completes normally; no further reads.
REQ-028 rx_fifo_empty rising after READ is ignored for the in-flight byte.
REQ-029 clear (any state): next cycle state=IDLE, counters/first_err/done zeroed, expected=START_VAL, in-flight byte discarded, no byte_valid.
REQ-030 clear and READ-entry condition same cycle: clear wins; no rx_rd_en.
REQ-031 rx_count and err_count saturate at 16'hFFFF.
REQ-032 rx_rd_en never asserted while rx_fifo_empty was high in the preceding IDLE decision.

Reset
REQ-033 On rst=1 at posedge clk: state=IDLE, rx_rd_en=0, byte_valid=0, mismatch=0, byte_data=0, rx_count=0, err_count=0, first_err=0, done=0, expected=START_VAL.
REQ-034 rst mid-operation abandons in-flight byte; a byte already removed from the FIFO is lost.
REQ-035 rst has priority over clear.

Structure
REQ-036 State enum and checker width constants reside in shared package uart_pkg.
REQ-037 Saturating counter is sub-module uart_sat_cnt (width parameter, inc, clr), instantiated twice.
REQ-038 All outputs registered; no combinational path from inputs to outputs.

Verification
REQ-039 FIFO preloaded 0..15, enable=1 -> 16 byte_valid pulses, rx_rd_en spacing 3 cycles, rx_count=16, err_count=0, done=1.
REQ-040 Sequence 0,1,2,7,4 with NUM_BYTES=5 -> mismatch at 4th byte, err_count=1, first_err=16'h0307.
REQ-041 START_VAL=8'hFE, bytes FE,FF,00 -> zero mismatches (wrap).
REQ-042 enable dropped the cycle after rx_rd_en -> that byte still checked, no next rx_rd_en while enable=0.
REQ-043 clear asserted in WAIT -> no byte_valid, counters 0, next byte compared to START_VAL.
REQ-044 rst asserted in CHECK -> all outputs at reset values the following cycle; FIFO empty -> rx_rd_en stays 0.
